// File: rtl/inv_adder_annealed_sampler_pkg.sv
// Shared definitions for the annealed invertible-adder sampler.
// Provides the run-control FSM state type, the clamping-mode encodings
// and the default widths used by the top, the core and the bus interface.
package inv_adder_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int I_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURN   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] FWD = 2'd0;  // a, b clamped; sum, overflow free
  localparam logic [1:0] INV = 2'd1;  // sum clamped; a, b, overflow free
  localparam logic [1:0] SUB = 2'd2;  // a, sum clamped; b, overflow free

endpackage

// File: rtl/inv_adder_annealed_sampler_if.sv
// Bus interface of the annealed sampler.
// Run request/configuration (start, mode, update_mode, a, b, sum, log_tau,
// i_min, i_max, num_samples) flows master -> slave; status (busy, done, i_0),
// raw core state (a_out, b_out, sum_out, overflow) and the majority results
// (a_maj, b_maj, sum_maj, ovf_maj) flow slave -> master.
interface inv_adder_annealed_sampler_if
  import inv_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int I_W   = I_W_DEF
);
  logic             start;
  logic [1:0]       mode;
  logic             update_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [3:0]       log_tau;
  logic [I_W-1:0]   i_min;
  logic [I_W-1:0]   i_max;
  logic [CNT_W-1:0] num_samples;
  logic             busy;
  logic             done;
  logic [I_W-1:0]   i_0;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] sum_out;
  logic             overflow;
  logic [WIDTH-1:0] a_maj;
  logic [WIDTH-1:0] b_maj;
  logic [WIDTH-1:0] sum_maj;
  logic             ovf_maj;

  modport master (
    output start, mode, update_mode, a, b, sum, log_tau, i_min, i_max, num_samples,
    input  busy, done, i_0, a_out, b_out, sum_out, overflow,
           a_maj, b_maj, sum_maj, ovf_maj
  );

  modport slave (
    input  start, mode, update_mode, a, b, sum, log_tau, i_min, i_max, num_samples,
    output busy, done, i_0, a_out, b_out, sum_out, overflow,
           a_maj, b_maj, sum_maj, ovf_maj
  );
endinterface

// File: rtl/inv_adder_annealed_sampler_core.sv
// inv_ripple_adder_n: stochastic invertible ripple adder.
// Clamped variables follow their inputs every cycle; free variables are
// recomputed from the adder relation and perturbed by LFSR noise whose rate
// falls as I_0 rises (no noise once I_0 reaches the top of the 4-bit noise
// range). update_mode=1 refreshes all free variables each cycle, 0 alternates
// between the two groups of free variables.
// Ports: clk, rst (sync, active-high), I_0 strength, mode, update_mode,
//        a_in/b_in/sum_in clamp values, a_out/b_out/sum_out/overflow state.
module inv_ripple_adder_n
  import inv_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int I_W   = I_W_DEF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [I_W-1:0]   I_0,
  input  logic [1:0]       mode,
  input  logic             update_mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             overflow
);

  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic             c;
    logic [WIDTH-1:0] s;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  function automatic logic carry_out(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
    logic c;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    return c;
  endfunction

  logic [15:0]      lfsr;
  logic             phase;
  logic             hot;
  logic [WIDTH-1:0] mask;
  logic [WIDTH:0]   fwd;
  logic             upd1;
  logic             upd2;

  always_comb begin
    // Noise fires when the random nibble exceeds the current strength.
    hot  = int'(lfsr[15:12]) > int'(I_0);
    mask = hot ? lfsr[WIDTH-1:0] : '0;
    fwd  = ripple_add(a_in, b_in);
    upd1 = update_mode | ~phase;
    upd2 = update_mode | phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= 16'hACE1;
      phase    <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      sum_out  <= '0;
      overflow <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      phase <= ~phase;
      case (mode)
        INV: begin
          sum_out <= sum_in;
          if (upd1) a_out <= a_out ^ mask;
          if (upd2) begin
            b_out    <= sum_in - a_out;
            overflow <= carry_out(a_out, b_out);
          end
        end
        SUB: begin
          a_out   <= a_in;
          sum_out <= sum_in;
          if (upd1) b_out    <= (sum_in - a_in) ^ mask;
          if (upd2) overflow <= carry_out(a_in, b_out);
        end
        default: begin
          a_out <= a_in;
          b_out <= b_in;
          if (upd1) sum_out  <= fwd[WIDTH-1:0] ^ mask;
          if (upd2) overflow <= fwd[WIDTH];
        end
      endcase
    end
  end

endmodule

// File: rtl/inv_adder_annealed_sampler.sv
// inv_adder_annealed_sampler: runs the invertible adder core through an
// annealing burn-in (strength ramps i_min -> i_max, one step per 2^log_tau
// cycles) and then counts, per output bit, how often it is 1 over
// num_samples cycles; DONE publishes the per-bit majority.
// Ports: clk, reset (async, active-low), bus (slave modport: run request,
//        configuration, status, raw core state and majority results).
module inv_adder_annealed_sampler
  import inv_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int I_W   = I_W_DEF
)(
  input  logic clk,
  input  logic reset,
  inv_adder_annealed_sampler_if.slave bus
);

  localparam int BW = I_W + 16;       // holds (2^I_W - 1) << 15
  localparam int NB = 3 * WIDTH + 1;  // a, b, sum bits plus overflow

  state_t           state;
  logic [1:0]       mode_q;
  logic             upd_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [3:0]       lt_q;
  logic [I_W-1:0]   imin_q, imax_q, i_0_q;
  logic [CNT_W-1:0] ns_q, samp_cnt;
  logic [15:0]      tau_cnt, tau_max;
  logic [BW-1:0]    burn_len, burn_cnt;
  logic             busy_q, done_q, core_rst;

  logic [NB-1:0][CNT_W-1:0] cnt, cnt_nx;
  logic [NB-1:0]            smp, maj, maj_nx;

  function automatic logic maj_bit(input logic [CNT_W-1:0] c,
                                   input logic [CNT_W-1:0] n);
    return {c, 1'b0} > {1'b0, n};
  endfunction

  // Configuration is captured only when a run is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      mode_q <= bus.mode;
      upd_q  <= bus.update_mode;
      a_q    <= bus.a;
      b_q    <= bus.b;
      sum_q  <= bus.sum;
      lt_q   <= bus.log_tau;
      imin_q <= bus.i_min;
      imax_q <= bus.i_max;
      ns_q   <= bus.num_samples;
    end
  end

  always_comb begin
    burn_len = (imax_q > imin_q) ? (BW'(imax_q - imin_q) << lt_q) : '0;
    tau_max  = (16'd1 << lt_q) - 16'd1;
    core_rst = (state == IDLE);
    smp      = {bus.overflow, bus.sum_out, bus.b_out, bus.a_out};
    for (int i = 0; i < NB; i++) begin
      cnt_nx[i] = cnt[i];
      if (state == SAMPLE && smp[i]) cnt_nx[i] = cnt[i] + CNT_W'(1);
      maj_nx[i] = maj_bit(cnt_nx[i], ns_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      i_0_q    <= '0;
      tau_cnt  <= '0;
      burn_cnt <= '0;
      samp_cnt <= '0;
      cnt      <= '0;
      maj      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= BURN;
            busy_q   <= 1'b1;
            i_0_q    <= bus.i_min;
            tau_cnt  <= '0;
            burn_cnt <= '0;
            samp_cnt <= '0;
            cnt      <= '0;
          end
        end
        BURN: begin
          if (tau_cnt == tau_max) begin
            tau_cnt <= '0;
            if (i_0_q < imax_q) i_0_q <= i_0_q + I_W'(1);
          end else begin
            tau_cnt <= tau_cnt + 16'd1;
          end
          // The entry cycle releases the core; burn_len cycles follow it.
          if (burn_cnt == burn_len) begin
            if (ns_q == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
              maj    <= maj_nx;
            end else begin
              state <= SAMPLE;
            end
          end else begin
            burn_cnt <= burn_cnt + BW'(1);
          end
        end
        SAMPLE: begin
          cnt      <= cnt_nx;
          samp_cnt <= samp_cnt + CNT_W'(1);
          if (samp_cnt == ns_q - CNT_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
            maj    <= maj_nx;  // includes the final sample
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  inv_ripple_adder_n #(.WIDTH(WIDTH), .I_W(I_W)) u_core (
    .clk         (clk),
    .rst         (core_rst),
    .I_0         (i_0_q),
    .mode        (mode_q),
    .update_mode (upd_q),
    .a_in        (a_q),
    .b_in        (b_q),
    .sum_in      (sum_q),
    .a_out       (bus.a_out),
    .b_out       (bus.b_out),
    .sum_out     (bus.sum_out),
    .overflow    (bus.overflow)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.i_0     = i_0_q;
  assign bus.a_maj   = maj[WIDTH-1:0];
  assign bus.b_maj   = maj[2*WIDTH-1:WIDTH];
  assign bus.sum_maj = maj[3*WIDTH-1:2*WIDTH];
  assign bus.ovf_maj = maj[NB-1];

endmodule
